// File: rtl/nco_fft_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module      : nco_fft_wrapper_if
// Description : Bundles the NCO, framer and FFT power-stage signals of
//               nco_fft_wrapper into one interface with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface nco_fft_wrapper_if #(
    parameter int PHASE_W  = 32,
    parameter int OUT_W    = 14,
    parameter int PWR_IN_W = 13
);
    logic                          clken;
    logic        [PHASE_W-1:0]     phi_inc_i;
    logic signed [OUT_W-1:0]       fsin_o;
    logic signed [OUT_W-1:0]       fcos_o;
    logic                          out_valid;

    logic signed [OUT_W-1:0]       in_signal;
    logic signed [OUT_W-1:0]       sink_data;
    logic                          sink_valid;
    logic                          sink_sop;
    logic                          sink_eop;

    logic                          src_valid;
    logic                          src_sop;
    logic signed [PWR_IN_W-1:0]    src_real;
    logic signed [PWR_IN_W-1:0]    src_imag;
    logic        [2*PWR_IN_W-2:0]  real_power;
    logic        [2*PWR_IN_W-2:0]  imag_power;
    logic                          fft_source_sop;
    logic                          power_valid;

    modport slave (
        input  clken, phi_inc_i, in_signal,
        input  src_valid, src_sop, src_real, src_imag,
        output fsin_o, fcos_o, out_valid,
        output sink_data, sink_valid, sink_sop, sink_eop,
        output real_power, imag_power, fft_source_sop, power_valid
    );

    modport master (
        output clken, phi_inc_i, in_signal,
        output src_valid, src_sop, src_real, src_imag,
        input  fsin_o, fcos_o, out_valid,
        input  sink_data, sink_valid, sink_sop, sink_eop,
        input  real_power, imag_power, fft_source_sop, power_valid
    );
endinterface
`default_nettype wire

// File: rtl/nco_fft_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : nco_fft_wrapper
// Description : Phase-accumulator NCO (sin/cos), FFT_N-point sample framer and
//               FFT output power stage. Define NCO_QUARTER_WAVE_EN to build the
//               sine ROM from a 257-entry quarter-wave table.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_fft_wrapper #(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = 10,
    parameter int OUT_W    = 14,
    parameter int FFT_N    = 1024,
    parameter int PWR_IN_W = 13
) (
    input  logic             clk,
    input  logic             reset_n,
    nco_fft_wrapper_if.slave bus
);
    localparam int  c_LUT_N = 1 << LUT_AW;
    localparam int  c_QTR   = c_LUT_N / 4;
    localparam int  c_AMP   = (1 << (OUT_W - 1)) - 1;
    localparam int  c_CNT_W = $clog2(FFT_N);
    localparam int  c_PWR_W = 2 * PWR_IN_W - 1;
    localparam real c_PI    = 3.14159265358979323846;

    // First-quadrant sample round(c_AMP*sin(2*pi*j/c_LUT_N)), j in 0..c_QTR,
    // evaluated by Taylor series so the table is a pure elaboration constant.
    function automatic logic signed [OUT_W-1:0] f_quarter(input int j);
        real x;
        real term;
        real acc;
        x    = c_PI * real'(j) / real'(2 * c_QTR);
        acc  = x;
        term = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return OUT_W'($rtoi(acc * real'(c_AMP) + 0.5));
    endfunction

    // Full-circle entry built from the same quarter values, so both builds
    // produce bit-identical outputs.
    function automatic logic signed [OUT_W-1:0] f_sine(input int k);
        logic signed [OUT_W-1:0] m;
        if (((k / c_QTR) % 2) == 0)
            m = f_quarter(k % c_QTR);
        else
            m = f_quarter(c_QTR - (k % c_QTR));
        return (k >= 2 * c_QTR) ? -m : m;
    endfunction

    logic        [PHASE_W-1:0]  r_phase;
    logic        [LUT_AW-1:0]   r_k;
    logic                       r_v1;
    logic signed [OUT_W-1:0]    r_fsin;
    logic signed [OUT_W-1:0]    r_fcos;
    logic                       r_ov;

    logic        [LUT_AW-1:0]   w_kc;
    logic signed [OUT_W-1:0]    w_sin;
    logic signed [OUT_W-1:0]    w_cos;

    assign w_kc = r_k + LUT_AW'(c_QTR);

`ifdef NCO_QUARTER_WAVE_EN
    logic signed [OUT_W-1:0]    w_qlut [0:c_QTR];
    logic        [LUT_AW-2:0]   w_sa;
    logic        [LUT_AW-2:0]   w_ca;

    for (genvar g = 0; g <= c_QTR; g++) begin : g_qlut
        assign w_qlut[g] = f_quarter(g);
    end

    // Odd quadrants read the table mirrored, the lower half-circle negated.
    always_comb begin
        w_sa  = r_k[LUT_AW-2]  ? ((LUT_AW-1)'(c_QTR) - {1'b0, r_k[LUT_AW-3:0]})
                               : {1'b0, r_k[LUT_AW-3:0]};
        w_ca  = w_kc[LUT_AW-2] ? ((LUT_AW-1)'(c_QTR) - {1'b0, w_kc[LUT_AW-3:0]})
                               : {1'b0, w_kc[LUT_AW-3:0]};
        w_sin = r_k[LUT_AW-1]  ? -w_qlut[w_sa] : w_qlut[w_sa];
        w_cos = w_kc[LUT_AW-1] ? -w_qlut[w_ca] : w_qlut[w_ca];
    end
`else
    logic signed [OUT_W-1:0]    w_lut [0:c_LUT_N-1];

    for (genvar g = 0; g < c_LUT_N; g++) begin : g_lut
        assign w_lut[g] = f_sine(g);
    end

    assign w_sin = w_lut[r_k];
    assign w_cos = w_lut[w_kc];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_k     <= '0;
            r_v1    <= 1'b0;
            r_fsin  <= '0;
            r_fcos  <= '0;
            r_ov    <= 1'b0;
        end else if (bus.clken) begin
            r_phase <= r_phase + bus.phi_inc_i;
            r_k     <= r_phase[PHASE_W-1 -: LUT_AW];
            r_v1    <= 1'b1;
            r_fsin  <= w_sin;
            r_fcos  <= w_cos;
            r_ov    <= r_v1;
        end
    end

    logic        [c_CNT_W-1:0]  r_cnt;
    logic signed [OUT_W-1:0]    r_sdata;
    logic                       r_svalid;
    logic                       r_ssop;
    logic                       r_seop;

    // Counter holds while out_valid is low, so a frame can stall mid-packet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_sdata  <= '0;
            r_svalid <= 1'b0;
            r_ssop   <= 1'b0;
            r_seop   <= 1'b0;
        end else if (r_ov) begin
            r_sdata  <= bus.in_signal;
            r_svalid <= 1'b1;
            r_ssop   <= (r_cnt == '0);
            r_seop   <= (r_cnt == c_CNT_W'(FFT_N - 1));
            r_cnt    <= r_cnt + 1'b1;
        end else begin
            r_svalid <= 1'b0;
            r_ssop   <= 1'b0;
            r_seop   <= 1'b0;
        end
    end

    logic signed [c_PWR_W-1:0]  w_re;
    logic signed [c_PWR_W-1:0]  w_im;
    logic        [c_PWR_W-1:0]  w_rsq;
    logic        [c_PWR_W-1:0]  w_isq;
    logic        [c_PWR_W-1:0]  r_rpwr;
    logic        [c_PWR_W-1:0]  r_ipwr;
    logic                       r_psop;
    logic                       r_pvalid;

    // Squares are formed at full power width; (-2^(W-1))^2 = 2^(2W-2) still fits.
    assign w_re  = c_PWR_W'(bus.src_real);
    assign w_im  = c_PWR_W'(bus.src_imag);
    assign w_rsq = w_re * w_re;
    assign w_isq = w_im * w_im;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rpwr   <= '0;
            r_ipwr   <= '0;
            r_psop   <= 1'b0;
            r_pvalid <= 1'b0;
        end else begin
            r_psop   <= bus.src_sop & bus.src_valid;
            r_pvalid <= bus.src_valid;
            if (bus.src_valid) begin
                r_rpwr <= w_rsq;
                r_ipwr <= w_isq;
            end
        end
    end

    assign bus.fsin_o         = r_fsin;
    assign bus.fcos_o         = r_fcos;
    assign bus.out_valid      = r_ov;
    assign bus.sink_data      = r_sdata;
    assign bus.sink_valid     = r_svalid;
    assign bus.sink_sop       = r_ssop;
    assign bus.sink_eop       = r_seop;
    assign bus.real_power     = r_rpwr;
    assign bus.imag_power     = r_ipwr;
    assign bus.fft_source_sop = r_psop;
    assign bus.power_valid    = r_pvalid;
endmodule
`default_nettype wire

// File: tb/tb_nco_fft_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_fft_wrapper
// Description : Scoreboard bench for nco_fft_wrapper against a sine/frame/power
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_fft_wrapper;
    localparam int       c_N    = 1024;
    localparam bit [31:0] c_INC0 = 32'd41943040;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nco_fft_wrapper_if #(.PHASE_W(32), .OUT_W(14), .PWR_IN_W(13)) bus ();

    nco_fft_wrapper #(
        .PHASE_W (32),
        .LUT_AW  (10),
        .OUT_W   (14),
        .FFT_N   (c_N),
        .PWR_IN_W(13)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct { int s; int c; }          nco_t;
    typedef struct { int d; bit sop; bit eop; } frm_t;
    typedef struct { int rp; int ip; bit sop; } pwr_t;

    nco_t q_nco[$];
    frm_t q_frm[$];
    pwr_t q_pwr[$];
    nco_t e_n;
    frm_t e_f;
    pwr_t e_p;

    int checks  = 0;
    int errors  = 0;
    int sop_cnt = 0;
    int eop_cnt = 0;
    int last_s  = 0;
    int last_c  = 0;
    int last_rp = 0;
    int last_ip = 0;

    bit [31:0] m_ph   = '0;
    int        m_en   = 0;
    bit        m_have = 1'b0;
    int        m_k    = 0;
    int        m_nfr  = 0;
    bit        m_ov   = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int sref(input int k);
        real v;
        v = 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        return -$rtoi($floor(-v + 0.5));
    endfunction

    function automatic int rnd14();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic int rnd13();
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    // Drive one cycle's inputs (called at a falling edge), record what the next
    // rising edge must produce, then advance to the following falling edge.
    task automatic step(input bit rn, input bit ce, input bit [31:0] inc, input int din,
                        input bit sv, input bit ssop, input int re, input int im);
        reset_n           = rn;
        bus.clken         = ce;
        bus.phi_inc_i     = inc;
        bus.in_signal     = 14'(din);
        bus.src_valid     = sv;
        bus.src_sop       = ssop;
        bus.src_real      = 13'(re);
        bus.src_imag      = 13'(im);
        if (!rn) begin
            m_ph    = '0;
            m_en    = 0;
            m_have  = 1'b0;
            m_nfr   = 0;
            m_ov    = 1'b0;
            sop_cnt = 0;
            eop_cnt = 0;
            last_rp = 0;
            last_ip = 0;
        end else begin
            if (m_ov) begin
                q_frm.push_back('{d: din, sop: ((m_nfr % c_N) == 0),
                                  eop: ((m_nfr % c_N) == c_N - 1)});
                m_nfr++;
            end
            if (sv) q_pwr.push_back('{rp: re * re, ip: im * im, sop: ssop});
            if (ce) begin
                if (m_have) q_nco.push_back('{s: sref(m_k), c: sref((m_k + 256) % 1024)});
                m_k    = int'(m_ph[31:22]);
                m_have = 1'b1;
                m_ph   = m_ph + inc;
                m_en++;
                if (m_en >= 2) m_ov = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        chk("out_valid", bus.out_valid, m_ov);
        if (bus.out_valid && bus.clken && reset_n) begin
            if (q_nco.size() == 0) begin
                checks++; errors++;
                $display("FAIL nco_extra actual=sample required=none");
            end else begin
                e_n = q_nco.pop_front();
                chk("fsin", bus.fsin_o, e_n.s);
                chk("fcos", bus.fcos_o, e_n.c);
                last_s = e_n.s;
                last_c = e_n.c;
            end
        end else if (bus.out_valid) begin
            chk("fsin_hold", bus.fsin_o, last_s);
            chk("fcos_hold", bus.fcos_o, last_c);
        end
        if (bus.sink_valid) begin
            if (q_frm.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_extra actual=sample required=none");
            end else begin
                e_f = q_frm.pop_front();
                chk("sink_data", bus.sink_data, e_f.d);
                chk("sink_sop",  bus.sink_sop,  e_f.sop);
                chk("sink_eop",  bus.sink_eop,  e_f.eop);
                if (bus.sink_sop) sop_cnt++;
                if (bus.sink_eop) eop_cnt++;
            end
        end
        if (bus.power_valid) begin
            if (q_pwr.size() == 0) begin
                checks++; errors++;
                $display("FAIL power_extra actual=sample required=none");
            end else begin
                e_p = q_pwr.pop_front();
                chk("real_power", bus.real_power, e_p.rp);
                chk("imag_power", bus.imag_power, e_p.ip);
                chk("src_sop_out", bus.fft_source_sop, e_p.sop);
                last_rp = e_p.rp;
                last_ip = e_p.ip;
            end
        end else begin
            chk("src_sop_idle", bus.fft_source_sop, 0);
            chk("rp_hold", bus.real_power, last_rp);
            chk("ip_hold", bus.imag_power, last_ip);
        end
    end

    bit [31:0] r_inc;

    initial begin
        bus.clken     = 1'b0;
        bus.phi_inc_i = '0;
        bus.in_signal = '0;
        bus.src_valid = 1'b0;
        bus.src_sop   = 1'b0;
        bus.src_real  = '0;
        bus.src_imag  = '0;
        @(negedge clk);

        repeat (3) step(0, 0, 32'd0, 0, 0, 0, 0, 0);
        chk("rst_fsin",   bus.fsin_o, 0);
        chk("rst_fcos",   bus.fcos_o, 0);
        chk("rst_ov",     bus.out_valid, 0);
        chk("rst_sdata",  bus.sink_data, 0);
        chk("rst_svalid", bus.sink_valid, 0);
        chk("rst_ssop",   bus.sink_sop, 0);
        chk("rst_seop",   bus.sink_eop, 0);
        chk("rst_rp",     bus.real_power, 0);
        chk("rst_ip",     bus.imag_power, 0);
        chk("rst_psop",   bus.fft_source_sop, 0);
        chk("rst_pvalid", bus.power_valid, 0);

        step(1, 1, c_INC0, rnd14(), 0, 0, 0, 0);
        step(1, 1, c_INC0, rnd14(), 1, 1, -4096, 4095);
        chk("first_ov",   bus.out_valid, 1);
        chk("first_fsin", bus.fsin_o, 0);
        chk("first_fcos", bus.fcos_o, 8191);
        chk("pwr_m4096",  bus.real_power, 16777216);
        chk("pwr_4095",   bus.imag_power, 16769025);
        chk("pwr_sop",    bus.fft_source_sop, 1);
        chk("pwr_valid",  bus.power_valid, 1);
        step(1, 1, c_INC0, rnd14(), 0, 0, 0, 0);
        chk("second_fsin", bus.fsin_o, 502);

        for (int i = 0; i < 3000 && m_nfr < 2100; i++)
            step(1, 1, c_INC0, rnd14(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd13(), rnd13());
        chk("sop_count", sop_cnt, 3);
        chk("eop_count", eop_cnt, 2);

        for (int i = 0; i < 1100 && (m_nfr % c_N) != 700; i++)
            step(1, 1, c_INC0, rnd14(), 0, 0, 0, 0);
        chk("reach_cnt700", m_nfr % c_N, 700);
        repeat (2) step(0, 1, c_INC0, rnd14(), 1, 1, rnd13(), rnd13());
        chk("rst2_svalid", bus.sink_valid, 0);
        chk("rst2_fsin",   bus.fsin_o, 0);

        r_inc = $urandom;
        step(1, 1, r_inc, rnd14(), 0, 0, 0, 0);
        step(1, 1, r_inc, rnd14(), 0, 0, 0, 0);
        chk("restart_fsin", bus.fsin_o, 0);
        chk("restart_fcos", bus.fcos_o, 8191);
        step(1, 1, r_inc, rnd14(), 0, 0, 0, 0);
        chk("restart_svalid", bus.sink_valid, 1);
        chk("restart_sop",    bus.sink_sop, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) r_inc = $urandom;
            step(1, 1'($urandom_range(0, 9) < 7), r_inc, rnd14(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd13(), rnd13());
        end

        repeat (3) step(1, 0, r_inc, 0, 0, 0, 0, 0);
        chk("nco_queue_empty", q_nco.size(), 0);
        chk("frm_queue_empty", q_frm.size(), 0);
        chk("pwr_queue_empty", q_pwr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
